// File: rtl/aclk_keyscan.sv
// 3x4 keypad scanner with ghost rejection; key updates the clock after EVAL.
// Optional debounce filter enabled by defining KEYSCAN_DEBOUNCE_EN.
module aclk_keyscan #(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scan_tick,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key,
  output logic       key_valid
);

  localparam logic [3:0] NOKEY = 4'd10;

  if (DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15) begin : g_bad_cnt
    $error("DEBOUNCE_CNT must be in 1..15");
  end

  typedef enum logic [1:0] {COL0, COL1, COL2, EVAL} state_t;

  state_t      state, state_nxt;
  logic [3:0]  row_s1, row_s2;
  logic [11:0] acc, acc_nxt;
  logic [2:0]  col_dec;
  logic [3:0]  hits, found, result;
  logic [3:0]  key_nxt;
  logic        key_valid_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= COL0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
    end
  end

  // acc bit index is col*4+row; the EVAL->COL0 transition clears it
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    col_dec   = 3'b111;
    case (state)
      COL0: begin
        col_dec = 3'b110;
        if (scan_tick) begin
          acc_nxt[3:0] = ~row_s2;
          state_nxt    = COL1;
        end
      end
      COL1: begin
        col_dec = 3'b101;
        if (scan_tick) begin
          acc_nxt[7:4] = ~row_s2;
          state_nxt    = COL2;
        end
      end
      COL2: begin
        col_dec = 3'b011;
        if (scan_tick) begin
          acc_nxt[11:8] = ~row_s2;
          state_nxt     = EVAL;
        end
      end
      EVAL: begin
        acc_nxt   = '0;
        state_nxt = COL0;
      end
      default: state_nxt = COL0;
    endcase
  end

  assign col = reset ? col_dec : 3'b111;

  // '*' (row3/col0) and '#' (row3/col2) never count toward ghost rejection
  always_comb begin
    hits  = 4'd0;
    found = NOKEY;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (acc[c*4+r] && !(r == 3 && c != 1)) begin
          hits  = hits + 4'd1;
          found = (r == 3) ? 4'd0 : 4'(r*3 + c + 1);
        end
      end
    end
    result = (hits == 4'd1) ? found : NOKEY;
  end

`ifdef KEYSCAN_DEBOUNCE_EN
  localparam logic [3:0] DB = 4'(DEBOUNCE_CNT);

  logic [3:0] cand, cand_nxt, cnt, cnt_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand <= NOKEY;
      cnt  <= 4'd0;
    end else begin
      cand <= cand_nxt;
      cnt  <= cnt_nxt;
    end
  end

  always_comb begin
    cand_nxt = cand;
    cnt_nxt  = cnt;
    key_nxt  = key;
    if (state == EVAL) begin
      if (result == cand) begin
        cnt_nxt = (cnt < DB) ? cnt + 4'd1 : cnt;
      end else begin
        cand_nxt = result;
        cnt_nxt  = 4'd1;
      end
      if (cnt_nxt == DB) key_nxt = cand_nxt;
    end
  end
`else
  always_comb begin
    key_nxt = key;
    if (state == EVAL) key_nxt = result;
  end
`endif

  assign key_valid_nxt = (state == EVAL) && (key == NOKEY) && (key_nxt != NOKEY);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key       <= NOKEY;
      key_valid <= 1'b0;
    end else begin
      key       <= key_nxt;
      key_valid <= key_valid_nxt;
    end
  end

endmodule

// File: tb/tb_aclk_keyscan.sv
// Bench for aclk_keyscan: keypad model drives rows from col, scoreboard holds
// the expected key/key_valid per frame; follows the DUT's KEYSCAN_DEBOUNCE_EN build.
module tb_aclk_keyscan;

  localparam int DB = 4;

  logic       clock;
  logic       reset;
  logic       scan_tick;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] key;
  logic       key_valid;

  aclk_keyscan #(.DEBOUNCE_CNT(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .scan_tick (scan_tick),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] key;
    logic       vld;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  int         exp_pulses = 0;
  int         pulses_seen = 0;
  logic [11:0] held;      // bit p = keypad position p = r*3+c
  logic        ovr_en;
  logic [3:0]  ovr_val;
  logic [3:0]  key_m, cand_m;
  int          cnt_m;

  // keypad: a held key pulls its row low while its column is driven low
  always_comb begin
    row = 4'b1111;
    if (ovr_en) begin
      row = ovr_val;
    end else begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 3; c++)
          if (held[r*3+c] && !col[c]) row[r] = 1'b0;
    end
  end

  always @(negedge clock) if (key_valid === 1'b1) pulses_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] frame_res(input logic [11:0] m);
    int         n = 0;
    logic [3:0] d = 4'd10;
    for (int p = 0; p < 12; p++) begin
      if (m[p] && p != 9 && p != 11) begin
        n++;
        d = (p == 10) ? 4'd0 : 4'(p + 1);
      end
    end
    return (n == 1) ? d : 4'd10;
  endfunction

  task automatic model_reset();
    key_m  = 4'd10;
    cand_m = 4'd10;
    cnt_m  = 0;
  endtask

  task automatic model_frame(input logic [11:0] m);
    logic [3:0] res, nk;
    logic       v;
    res = frame_res(m);
`ifdef KEYSCAN_DEBOUNCE_EN
    if (res == cand_m) begin
      if (cnt_m < DB) cnt_m++;
    end else begin
      cand_m = res;
      cnt_m  = 1;
    end
    nk = (cnt_m == DB) ? cand_m : key_m;
`else
    nk = res;
`endif
    v = (key_m == 4'd10) && (nk != 4'd10);
    if (v) exp_pulses++;
    key_m = nk;
    sb_q.push_back('{key: nk, vld: v});
  endtask

  task automatic run_frame(input logic [11:0] m);
    exp_t       e;
    logic [2:0] ec;
    held = m;
    for (int c = 0; c < 3; c++) begin
      repeat (4) @(negedge clock);
      ec = 3'b111;
      ec[c] = 1'b0;
      chk("col_hold", {29'd0, col}, {29'd0, ec});
      scan_tick = 1'b1;
      @(negedge clock);
      scan_tick = 1'b0;
      ec = 3'b111;
      if (c < 2) ec[c+1] = 1'b0;
      chk("col_step", {29'd0, col}, {29'd0, ec});
    end
    model_frame(m);
    @(negedge clock);
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty got=0 exp=1");
    end else begin
      e = sb_q.pop_front();
      chk("key", {28'd0, key}, {28'd0, e.key});
      chk("key_valid", {31'd0, key_valid}, {31'd0, e.vld});
    end
    @(negedge clock);
    chk("vld_1clk", {31'd0, key_valid}, 32'd0);
  endtask

  task automatic run_frames(input logic [11:0] m, input int n);
    for (int i = 0; i < n; i++) run_frame(m);
  endtask

  initial begin
    reset     = 1'b0;
    scan_tick = 1'b0;
    held      = '0;
    ovr_en    = 1'b1;
    ovr_val   = 4'b0000;
    model_reset();

    // reset held with all rows low and strobes arriving
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      scan_tick = (i % 3 == 0);
      chk("rst_col", {29'd0, col}, 32'd7);
      chk("rst_key", {28'd0, key}, 32'd10);
      chk("rst_vld", {31'd0, key_valid}, 32'd0);
    end
    @(negedge clock);
    scan_tick = 1'b0;
    ovr_en    = 1'b0;
    reset     = 1'b1;
    #1;
    chk("col_after_rst", {29'd0, col}, 32'd6);

    run_frames(12'b0000_0001_0000, 6);   // 5
    run_frames(12'b0000_0000_0000, 5);   // none
    run_frames(12'b0001_0000_0100, 5);   // 3 + 9 ghost
    run_frames(12'b0100_0000_0000, 2);   // 0 bounce
    run_frames(12'b0000_0000_0000, 5);
    run_frames(12'b1000_1000_0000, 5);   // # + 8
    run_frames(12'b1000_0000_0000, 5);   // # alone
    run_frames(12'b0010_0000_1000, 5);   // * + 4
    run_frames(12'b0000_0000_0011, 5);   // 1 + 2 ghost
    run_frames(12'b0000_0000_0000, 2);

    // reset while in COL1 holding 7
    held = 12'b0000_0100_0000;
    repeat (4) @(negedge clock);
    scan_tick = 1'b1;
    @(negedge clock);
    scan_tick = 1'b0;
    chk("pre_rst_col1", {29'd0, col}, 32'd5);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_rst_col", {29'd0, col}, 32'd7);
    chk("mid_rst_key", {28'd0, key}, 32'd10);
    chk("mid_rst_vld", {31'd0, key_valid}, 32'd0);
    model_reset();
    repeat (2) @(negedge clock);
    chk("mid_rst_col2", {29'd0, col}, 32'd7);
    reset = 1'b1;
    #1;
    chk("col_after_rst2", {29'd0, col}, 32'd6);
    run_frames(12'b0000_0100_0000, DB);  // 7
    run_frames(12'b0000_0000_0000, 2);

    repeat (3) @(negedge clock);
    chk("pulse_count", pulses_seen, exp_pulses);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aclk_keyscan.md
AClk_KEYSCAN -- requirements
Module: aclk_keyscan

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 4, meaning: consecutive identical frames required before the key output changes (range 1-15).
REQ-002 clock  input  1  system clock; all flops are rising-edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 scan_tick  input  1  single-cycle scan-step strobe; consecutive strobes are at least 3 clocks apart.
REQ-005 row  input  4  keypad row returns, active-low, pulled up externally.
REQ-006 col  output  3  keypad column drive, active-low, one-hot.
REQ-007 key  output  4  debounced digit 0-9; 10 (NOKEY) when no valid key is held; feeds the alarm-clock controller key input.
REQ-008 key_valid  output  1  one-clock pulse when key changes from NOKEY to a digit.

Function
REQ-009 row SHALL pass through a 2-flop synchronizer, reset value 4'b1111; all row uses below refer to the synchronized value.
REQ-010 Keypad map (col0/col1/col2): row0 = 1/2/3, row1 = 4/5/6, row2 = 7/8/9, row3 = */0/#; * and # SHALL count as no key.
REQ-011 The FSM SHALL have states COL0, COL1, COL2 and EVAL; reset state is COL0.
REQ-012 In COLn, col SHALL drive bit n low and the other bits high.
REQ-013 On scan_tick in COLn, rows SHALL be sampled into the frame accumulator; the state then advances COL0->COL1->COL2->EVAL.
REQ-014 Without scan_tick, the FSM SHALL hold its state.
REQ-015 EVAL SHALL last exactly one clock and return to COL0 unconditionally; col = 3'b111 in EVAL.
REQ-016 Frame result in EVAL: exactly one digit key pressed -> that digit; zero digit keys -> NOKEY; two or more digit keys -> NOKEY (ghost reject).
REQ-017 * or # pressed together with one digit SHALL NOT cause rejection; the result is the digit.
REQ-018 The frame accumulator SHALL clear on entry to COL0.
REQ-019 key and key_valid SHALL be registered and SHALL update in the clock after EVAL.
REQ-020 key_valid SHALL NOT pulse on a digit-to-different-digit change, on a digit-to-NOKEY change, or when key is unchanged.
REQ-021 key SHALL NOT take a value outside the range 0-10.

Reset
REQ-022 While reset is low: state = COL0, col = 3'b111, key = 10, key_valid = 0, synchronizer = 4'b1111, accumulator and debounce counter = 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; after release, scanning restarts at COL0 on the next scan_tick.
REQ-024 In the first clock after reset is released, col SHALL be 3'b110.

Configuration
REQ-025 Macro KEYSCAN_DEBOUNCE_EN controls debouncing.
REQ-026 With KEYSCAN_DEBOUNCE_EN defined: candidate register plus 4-bit stable counter.
  - EVAL result equals candidate: the counter increments, saturating at DEBOUNCE_CNT.
  - EVAL result differs: candidate = result and counter = 1.
  - key updates to the candidate only when the counter reaches DEBOUNCE_CNT.
REQ-027 Without KEYSCAN_DEBOUNCE_EN: key SHALL take the EVAL result directly every frame; no candidate or counter logic is present.

Verification
REQ-028 Reset low with row = 4'b0000 -> col = 3'b111, key = 10, key_valid = 0 throughout.
REQ-029 Hold key 5 (row1 low while col1 low), debounce enabled, DEBOUNCE_CNT = 4 -> key = 5 after the 4th EVAL, one key_valid pulse, none afterwards.
REQ-030 Press 3 and 9 together -> key stays 10 and no key_valid pulse occurs.
REQ-031 Press 0 for two frames then release, DEBOUNCE_CNT = 4 -> key stays 10 (bounce rejected); without the macro, key = 0 for two frames and then returns to 10.
REQ-032 Hold # plus 8 -> key = 8; hold # alone -> key = 10.
REQ-033 Assert reset during COL1 while holding 7 -> outputs are at reset values; after release, key = 7 after DEBOUNCE_CNT full frames.
